apb_bridge_param: RTL
=====================

Name: apb_bridge_param

Overview:
- Parametrised single-clock APB-to-APB bridge for the BFM / peripheral subsystem.
- Accepts one APB3 transfer from an upstream master and replays it on a decoded downstream slave slot.
- Returns read data, PREADY and PSLVERR upstream.
- Beyond the previous bridge it adds:
  - configurable address/data width and slot count;
  - a configurable decode field position;
  - write strobes;
  - a decode-error response for unpopulated slots;
  - an optional access timeout.

Parameters:
- ADDR_W, 32, address width (≥ SEL_LSB+4).
- DATA_W, 32, data width; multiple of 8.
- NSEL, 16, populated downstream slots, 1..16.
- SEL_LSB, 24, LSB of the 4-bit slot field PADDR[SEL_LSB+3:SEL_LSB].
- TIMEOUT, 256, ACCESS wait cycles before abort, 1..65535 (used only with the macro).

Ports:
- PCLK  in  1  bridge clock.
- PRESETN  in  1  reset; synchronous, active-low.
- PSEL_PM  in  1  upstream select.
- PADDR_PM  in  ADDR_W  upstream address.
- PWRITE_PM  in  1  upstream direction.
- PENABLE_PM  in  1  upstream enable.
- PWDATA_PM  in  DATA_W  upstream write data.
- PSTRB_PM  in  DATA_W/8  upstream byte strobes.
- PRDATA_PM  out  DATA_W  read data to master.
- PREADY_PM  out  1  one-cycle completion pulse.
- PSLVERR_PM  out  1  error flag, valid with PREADY_PM.
- PSEL_SC  out  NSEL  one-hot downstream select.
- PADDR_SC  out  ADDR_W  downstream address.
- PWRITE_SC  out  1  downstream direction.
- PENABLE_SC  out  1  downstream enable.
- PWDATA_SC  out  DATA_W  downstream write data.
- PSTRB_SC  out  DATA_W/8  downstream strobes.
- PRDATA_SC  in  DATA_W  slave read data.
- PREADY_SC  in  1  slave ready.
- PSLVERR_SC  in  1  slave error.
- TIMEOUT_EVT  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (PRESETN low at a PCLK edge): state IDLE; all outputs 0. Reset mid-transfer aborts with no upstream response.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- Start condition: penable_q registers PENABLE_PM.
  - Start is PSEL_PM & PENABLE_PM & ~penable_q while in IDLE.
  - This edge detect prevents re-trigger while the master holds PENABLE after PREADY.
- IDLE → SETUP on start:
  - Capture PADDR/PWRITE/PWDATA/PSTRB.
  - Decode idx = PADDR_PM[SEL_LSB+3:SEL_LSB].
  - If idx ≥ NSEL, go IDLE → RESP instead (decode error).
- SETUP (1 cycle): PSEL_SC[idx]=1, PENABLE_SC=0, captured fields driven; → ACCESS.
- ACCESS: PSEL_SC[idx]=1, PENABLE_SC=1.
  - When PREADY_SC=1 is sampled: latch PRDATA_SC→PRDATA_PM and PSLVERR_SC→PSLVERR_PM; → RESP.
- RESP (1 cycle): PREADY_PM=1; → IDLE.
- Decode error response: PRDATA_PM=0, PSLVERR_PM=1; downstream never selected.
- Outside SETUP/ACCESS: PSEL_SC, PENABLE_SC, PADDR_SC, PWDATA_SC, PWRITE_SC, PSTRB_SC are all 0.
- PRDATA_PM and PSLVERR_PM hold until the next RESP.
- Latency: PENABLE_PM rises in cycle t; with a zero-wait slave PREADY_PM=1 in cycle t+3. Each slave wait adds 1. Decode error gives PREADY_PM in t+1.
- Upstream PSEL/PENABLE dropping mid-transfer is ignored: downstream completes and the RESP pulse is still issued.
- Writes also latch PRDATA_SC (don't-care upstream).

Optional Feature:
- Macro APB_BRIDGE_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on ACCESS entry and increments each ACCESS cycle with PREADY_SC=0.
  - When the count reaches TIMEOUT-1 with PREADY_SC still 0: drop downstream signals, → RESP with PRDATA_PM=0, PSLVERR_PM=1, and pulse TIMEOUT_EVT in the RESP cycle.
  - PREADY_SC=1 on the same cycle wins (normal completion).
- Undefined: no counter; ACCESS waits indefinitely; TIMEOUT_EVT tied 0.

Decomposition:
- Package apb_bridge_pkg holds:
  - the state enum (IDLE/SETUP/ACCESS/RESP, 2 bits);
  - SEL_FIELD_W=4 and MAX_SEL=16;
  - TO_CNT_W=16.
- Sub-module apb_sel_decode: combinational; inputs idx[3:0] and an active flag; outputs one-hot PSEL_SC[NSEL-1:0] and dec_err (idx ≥ NSEL).

Test Plan:
- Zero-wait write: PADDR_PM=0x0300_0010, PWDATA=0xA5A5_0001, PSTRB=0xF → PSEL_SC=0x0008 in t+1, PENABLE_SC in t+2, PREADY_PM in t+3, PSLVERR_PM=0.
- Read, 2 wait states: PADDR_PM=0x0000_0004, slave returns 0xDEAD_BEEF → PREADY_PM in t+5, PRDATA_PM=0xDEAD_BEEF, held after the pulse.
- Decode error: NSEL=4, PADDR_PM=0x0700_0000 → PSEL_SC stays 0, PREADY_PM in t+1, PSLVERR_PM=1, PRDATA_PM=0.
- Slave error: PSLVERR_SC=1 with PREADY_SC → PSLVERR_PM=1 in the RESP cycle; next clean transfer returns PSLVERR_PM=0.
- Timeout (macro on, TIMEOUT=8), PREADY_SC stuck 0 → abort after 8 ACCESS cycles, TIMEOUT_EVT=1 for one cycle coincident with PREADY_PM=1 and PSLVERR_PM=1. Macro off → no response for 100 cycles.
- Reset in ACCESS: PRESETN=0 for 1 cycle → next cycle all outputs 0, no PREADY_PM pulse; a following transfer completes normally with PREADY_PM at t+3 and PSLVERR_PM=0.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// rtl/apb_bridge_pkg.sv - shared state encoding and constants for the parametrised APB bridge
`timescale 1ns/1ps
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int SEL_FIELD_W = 4;
    localparam int MAX_SEL     = 16;
    localparam int TO_CNT_W    = 16;

endpackage

// File: rtl/apb_sel_decode.sv
// rtl/apb_sel_decode.sv - slot field to one-hot downstream select, flags unpopulated slots
`timescale 1ns/1ps
module apb_sel_decode
    import apb_bridge_pkg::*;
#(
    parameter int NSEL = 16
) (
    input  logic [SEL_FIELD_W-1:0] idx,
    input  logic                   active,
    output logic [NSEL-1:0]        sel,
    output logic                   dec_err
);

    always_comb begin
        sel     = '0;
        dec_err = (int'(idx) >= NSEL);
        for (int i = 0; i < NSEL; i++) begin
            if (active && (idx == SEL_FIELD_W'(i))) begin
                sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_bridge_param.sv
// rtl/apb_bridge_param.sv - APB3 upstream-to-downstream bridge; APB_BRIDGE_TIMEOUT_EN adds an ACCESS timeout
`timescale 1ns/1ps
module apb_bridge_param
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NSEL    = 16,
    parameter int SEL_LSB = 24,
    parameter int TIMEOUT = 256
) (
    input  logic                PCLK,
    input  logic                PRESETN,
    input  logic                PSEL_PM,
    input  logic [ADDR_W-1:0]   PADDR_PM,
    input  logic                PWRITE_PM,
    input  logic                PENABLE_PM,
    input  logic [DATA_W-1:0]   PWDATA_PM,
    input  logic [DATA_W/8-1:0] PSTRB_PM,
    output logic [DATA_W-1:0]   PRDATA_PM,
    output logic                PREADY_PM,
    output logic                PSLVERR_PM,
    output logic [NSEL-1:0]     PSEL_SC,
    output logic [ADDR_W-1:0]   PADDR_SC,
    output logic                PWRITE_SC,
    output logic                PENABLE_SC,
    output logic [DATA_W-1:0]   PWDATA_SC,
    output logic [DATA_W/8-1:0] PSTRB_SC,
    input  logic [DATA_W-1:0]   PRDATA_SC,
    input  logic                PREADY_SC,
    input  logic                PSLVERR_SC,
    output logic                TIMEOUT_EVT
);

    localparam int STRB_W = DATA_W / 8;

    state_t                 state, state_nxt;
    logic                   penable_q;
    logic [ADDR_W-1:0]      addr_q;
    logic                   write_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [STRB_W-1:0]      strb_q;
    logic [SEL_FIELD_W-1:0] idx_q;
    logic [SEL_FIELD_W-1:0] dec_idx;
    logic [DATA_W-1:0]      prdata_q;
    logic                   pslverr_q;
    logic                   timeout_q;
    logic                   start;
    logic                   active;
    logic                   dec_err;
    logic                   timed_out;
    logic [NSEL-1:0]        sel;

    // Rising-edge detect so a master still holding PENABLE after PREADY cannot re-trigger.
    assign start  = PSEL_PM && PENABLE_PM && !penable_q;
    assign active = (state == SETUP) || (state == ACCESS);

    // In IDLE the decoder looks at the live address to choose SETUP vs decode error.
    assign dec_idx = (state == IDLE) ? PADDR_PM[SEL_LSB +: SEL_FIELD_W] : idx_q;

    apb_sel_decode #(.NSEL(NSEL)) u_sel_decode (
        .idx     (dec_idx),
        .active  (active),
        .sel     (sel),
        .dec_err (dec_err)
    );

`ifdef APB_BRIDGE_TIMEOUT_EN
    logic [TO_CNT_W-1:0] to_cnt;

    always_ff @(posedge PCLK) begin
        if (!PRESETN || state != ACCESS) begin
            to_cnt <= '0;
        end else if (!PREADY_SC) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timed_out = (state == ACCESS) && !PREADY_SC && (to_cnt == TO_CNT_W'(TIMEOUT - 1));
`else
    logic unused_to;
    assign unused_to = (TIMEOUT < (1 << TO_CNT_W));
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = dec_err ? RESP : SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (PREADY_SC || timed_out) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            state     <= IDLE;
            penable_q <= 1'b0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            idx_q     <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            penable_q <= PENABLE_PM;
            timeout_q <= 1'b0;
            if (state == IDLE && start) begin
                addr_q  <= PADDR_PM;
                write_q <= PWRITE_PM;
                wdata_q <= PWDATA_PM;
                strb_q  <= PSTRB_PM;
                idx_q   <= dec_idx;
                if (dec_err) begin
                    prdata_q  <= '0;
                    pslverr_q <= 1'b1;
                end
            end
            if (state == ACCESS) begin
                if (PREADY_SC) begin
                    prdata_q  <= PRDATA_SC;
                    pslverr_q <= PSLVERR_SC;
                end else if (timed_out) begin
                    prdata_q  <= '0;
                    pslverr_q <= 1'b1;
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    assign PSEL_SC     = sel;
    assign PENABLE_SC  = (state == ACCESS);
    assign PADDR_SC    = active ? addr_q  : '0;
    assign PWRITE_SC   = active && write_q;
    assign PWDATA_SC   = active ? wdata_q : '0;
    assign PSTRB_SC    = active ? strb_q  : '0;
    assign PREADY_PM   = (state == RESP);
    assign PRDATA_PM   = prdata_q;
    assign PSLVERR_PM  = pslverr_q;
    assign TIMEOUT_EVT = timeout_q;

endmodule
